fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/VALID handshake with instruction memory and next-PC select.
// Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        FETCH_REQ,
   input  logic [1:0]  PC_MUX_SEL,
   input  logic [7:0]  BR_OFFSET,
   input  logic [15:0] JMP_ADDR,
   output logic        IMEM_REQ,
   output logic [15:0] IMEM_ADDR,
   input  logic        IMEM_ACK,
   input  logic [15:0] IMEM_RDATA,
   output logic [15:0] INSTRUCTION,
   output logic        INST_VALID,
   output logic [15:0] PC,
   output logic        BUSY,
   output logic        FETCH_ERR
);

   typedef enum logic [1:0] {StIdle, StReq, StValid} state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] instr_q, instr_d;
   logic        first_q, first_d;
   logic [15:0] br_sext;
   logic [15:0] next_pc;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [7:0]  TimeoutLast = 8'd254;
   localparam logic [15:0] TimeoutInstr = 16'hF000;

   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
`endif

   assign br_sext = {{8{BR_OFFSET[7]}}, BR_OFFSET};

   always_comb begin
      next_pc = pc_q;
      case (PC_MUX_SEL)
         2'b00:   next_pc = pc_q + 16'd1;
         2'b01:   next_pc = pc_q + 16'd1 + br_sext;
         2'b10:   next_pc = JMP_ADDR;
         default: next_pc = pc_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      first_d = first_q;
`ifdef FETCH_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         StIdle: begin
            if (FETCH_REQ) begin
               pc_d    = first_q ? 16'h0000 : next_pc;
               first_d = 1'b0;
               state_d = StReq;
            end
         end
         StReq: begin
            if (IMEM_ACK) begin
               instr_d = IMEM_RDATA;
               state_d = StValid;
`ifdef FETCH_TIMEOUT_EN
               cnt_d   = 8'd0;
            end else if (cnt_q == TimeoutLast) begin
               // 255th REQ cycle without an ACK: give up and hand back a marker instruction
               instr_d = TimeoutInstr;
               err_d   = 1'b1;
               cnt_d   = 8'd0;
               state_d = StValid;
            end else begin
               cnt_d   = cnt_q + 8'd1;
`endif
            end
         end
         StValid: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= StIdle;
         pc_q    <= 16'h0000;
         instr_q <= 16'h0000;
         first_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         first_q <= first_d;
`ifdef FETCH_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign IMEM_REQ    = (state_q == StReq);
   assign IMEM_ADDR   = pc_q;
   assign INSTRUCTION = instr_q;
   assign INST_VALID  = (state_q == StValid);
   assign PC          = pc_q;
   assign BUSY        = (state_q != StIdle);
`ifdef FETCH_TIMEOUT_EN
   assign FETCH_ERR   = err_q;
`else
   assign FETCH_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

   logic        CLK;
   logic        RST_N;
   logic        FETCH_REQ;
   logic [1:0]  PC_MUX_SEL;
   logic [7:0]  BR_OFFSET;
   logic [15:0] JMP_ADDR;
   logic        IMEM_REQ;
   logic [15:0] IMEM_ADDR;
   logic        IMEM_ACK;
   logic [15:0] IMEM_RDATA;
   logic [15:0] INSTRUCTION;
   logic        INST_VALID;
   logic [15:0] PC;
   logic        BUSY;
   logic        FETCH_ERR;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   fetch_unit dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .FETCH_REQ  (FETCH_REQ),
      .PC_MUX_SEL (PC_MUX_SEL),
      .BR_OFFSET  (BR_OFFSET),
      .JMP_ADDR   (JMP_ADDR),
      .IMEM_REQ   (IMEM_REQ),
      .IMEM_ADDR  (IMEM_ADDR),
      .IMEM_ACK   (IMEM_ACK),
      .IMEM_RDATA (IMEM_RDATA),
      .INSTRUCTION(INSTRUCTION),
      .INST_VALID (INST_VALID),
      .PC         (PC),
      .BUSY       (BUSY),
      .FETCH_ERR  (FETCH_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_pc"},    PC, 16'h0000);
      chk({tag, "_instr"}, INSTRUCTION, 16'h0000);
      chk({tag, "_req"},   {15'd0, IMEM_REQ}, 16'd0);
      chk({tag, "_addr"},  IMEM_ADDR, 16'h0000);
      chk({tag, "_valid"}, {15'd0, INST_VALID}, 16'd0);
      chk({tag, "_busy"},  {15'd0, BUSY}, 16'd0);
      chk({tag, "_err"},   {15'd0, FETCH_ERR}, 16'd0);
   endtask

   // Full fetch: request, nwait REQ cycles without ACK, then ACK with rdata.
   task automatic do_fetch(input string tag, input logic [1:0] sel, input logic [7:0] off,
                           input logic [15:0] jmp, input logic [15:0] exp_addr,
                           input logic [15:0] rdata, input int nwait);
      FETCH_REQ  = 1'b1;
      PC_MUX_SEL = sel;
      BR_OFFSET  = off;
      JMP_ADDR   = jmp;
      step();
      FETCH_REQ  = 1'b0;
      chk({tag, "_req"},  {15'd0, IMEM_REQ}, 16'd1);
      chk({tag, "_addr"}, IMEM_ADDR, exp_addr);
      chk({tag, "_pc"},   PC, exp_addr);
      for (int i = 0; i < nwait; i++) begin
         step();
         chk({tag, "_hold"}, IMEM_ADDR, exp_addr);
      end
      IMEM_ACK   = 1'b1;
      IMEM_RDATA = rdata;
      step();
      IMEM_ACK   = 1'b0;
      chk({tag, "_valid"}, {15'd0, INST_VALID}, 16'd1);
      chk({tag, "_instr"}, INSTRUCTION, rdata);
      chk({tag, "_dropreq"}, {15'd0, IMEM_REQ}, 16'd0);
      step();
      chk({tag, "_valid_end"}, {15'd0, INST_VALID}, 16'd0);
      chk({tag, "_idle"}, {15'd0, BUSY}, 16'd0);
      chk({tag, "_keep"}, INSTRUCTION, rdata);
   endtask

   initial begin
      int n;
      RST_N      = 1'b0;
      FETCH_REQ  = 1'b0;
      PC_MUX_SEL = 2'b00;
      BR_OFFSET  = 8'h00;
      JMP_ADDR   = 16'h0000;
      IMEM_ACK   = 1'b0;
      IMEM_RDATA = 16'h0000;
      step();
      step();
      chk_reset_outputs("reset");
      RST_N = 1'b1;
      step();

      // First fetch ignores the selector; ACK one cycle late.
      do_fetch("first", 2'b10, 8'h00, 16'h5555, 16'h0000, 16'h1234, 1);

      // Next-PC sources.
      do_fetch("jmp10",  2'b10, 8'h00, 16'h0010, 16'h0010, 16'hA001, 0);
      do_fetch("brneg",  2'b01, 8'hFC, 16'h0000, 16'h000D, 16'hA002, 1);
      do_fetch("jmp200", 2'b10, 8'h00, 16'h0200, 16'h0200, 16'hA003, 2);
      do_fetch("refet",  2'b11, 8'h00, 16'h0000, 16'h0200, 16'hA004, 0);
      do_fetch("brpos",  2'b01, 8'h7F, 16'h0000, 16'h0280, 16'hA005, 0);
      do_fetch("jmpff",  2'b10, 8'h00, 16'hFFFF, 16'hFFFF, 16'hA006, 0);
      do_fetch("wrap",   2'b00, 8'h00, 16'h0000, 16'h0000, 16'hA007, 0);
      do_fetch("inc",    2'b00, 8'h00, 16'h0000, 16'h0001, 16'hA008, 0);

      // ACK while idle must not load the instruction register.
      IMEM_ACK   = 1'b1;
      IMEM_RDATA = 16'hDEAD;
      step();
      IMEM_ACK   = 1'b0;
      chk("idle_ack_instr", INSTRUCTION, 16'hA008);
      chk("idle_ack_valid", {15'd0, INST_VALID}, 16'd0);

      // Slow memory with an extra FETCH_REQ during REQ and during VALID.
      FETCH_REQ  = 1'b1;
      PC_MUX_SEL = 2'b00;
      step();
      FETCH_REQ  = 1'b0;
      chk("slow_addr", IMEM_ADDR, 16'h0002);
      step();
      FETCH_REQ  = 1'b1;
      PC_MUX_SEL = 2'b10;
      JMP_ADDR   = 16'hBEEF;
      step();
      FETCH_REQ  = 1'b0;
      chk("slow_ign_addr", IMEM_ADDR, 16'h0002);
      chk("slow_ign_pc", PC, 16'h0002);
      chk("slow_ign_valid", {15'd0, INST_VALID}, 16'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("slow_wait_req", {15'd0, IMEM_REQ}, 16'd1);
         chk("slow_wait_valid", {15'd0, INST_VALID}, 16'd0);
      end
      IMEM_ACK   = 1'b1;
      IMEM_RDATA = 16'h5A5A;
      step();
      IMEM_ACK   = 1'b0;
      chk("slow_valid", {15'd0, INST_VALID}, 16'd1);
      chk("slow_instr", INSTRUCTION, 16'h5A5A);
      FETCH_REQ  = 1'b1;
      step();
      FETCH_REQ  = 1'b0;
      chk("slow_single", {15'd0, INST_VALID}, 16'd0);
      chk("slow_nobusy", {15'd0, BUSY}, 16'd0);
      chk("slow_pc", PC, 16'h0002);
      step();
      chk("slow_noreq", {15'd0, IMEM_REQ}, 16'd0);

      // Reset in the middle of REQ, then a stray ACK.
      FETCH_REQ  = 1'b1;
      PC_MUX_SEL = 2'b10;
      JMP_ADDR   = 16'h4321;
      step();
      FETCH_REQ  = 1'b0;
      chk("rst_pre_addr", IMEM_ADDR, 16'h4321);
      step();
      RST_N = 1'b0;
      #1;
      chk_reset_outputs("rst_async");
      step();
      step();
      chk_reset_outputs("rst_hold");
      RST_N      = 1'b1;
      IMEM_ACK   = 1'b1;
      IMEM_RDATA = 16'h7777;
      step();
      IMEM_ACK   = 1'b0;
      chk_reset_outputs("rst_stray");
      step();
      chk("rst_stray_valid", {15'd0, INST_VALID}, 16'd0);

      // First-fetch flag is set again by reset.
      do_fetch("refirst", 2'b10, 8'h00, 16'h1234, 16'h0000, 16'hC0DE, 0);

`ifdef FETCH_TIMEOUT_EN
      FETCH_REQ  = 1'b1;
      PC_MUX_SEL = 2'b00;
      step();
      FETCH_REQ  = 1'b0;
      n = 0;
      while (IMEM_REQ && n < 400) begin
         n++;
         step();
      end
      chk("to_cycles", n[15:0], 16'd255);
      chk("to_valid", {15'd0, INST_VALID}, 16'd1);
      chk("to_instr", INSTRUCTION, 16'hF000);
      chk("to_err", {15'd0, FETCH_ERR}, 16'd1);
      step();
      chk("to_valid_end", {15'd0, INST_VALID}, 16'd0);
      chk("to_err_hold", {15'd0, FETCH_ERR}, 16'd1);
      do_fetch("to_after", 2'b00, 8'h00, 16'h0000, 16'h0002, 16'h0BAD, 0);
      chk("to_err_sticky", {15'd0, FETCH_ERR}, 16'd1);
      RST_N = 1'b0;
      #1;
      chk("to_err_rst", {15'd0, FETCH_ERR}, 16'd0);
      step();
      RST_N = 1'b1;
      step();
`else
      FETCH_REQ  = 1'b1;
      PC_MUX_SEL = 2'b00;
      step();
      FETCH_REQ  = 1'b0;
      n = 0;
      while (IMEM_REQ && n < 300) begin
         n++;
         step();
      end
      chk("nto_cycles", n[15:0], 16'd300);
      chk("nto_req", {15'd0, IMEM_REQ}, 16'd1);
      chk("nto_err", {15'd0, FETCH_ERR}, 16'd0);
      chk("nto_addr", IMEM_ADDR, 16'h0001);
      IMEM_ACK   = 1'b1;
      IMEM_RDATA = 16'h0F0F;
      step();
      IMEM_ACK   = 1'b0;
      chk("nto_valid", {15'd0, INST_VALID}, 16'd1);
      chk("nto_instr", INSTRUCTION, 16'h0F0F);
      step();
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
